// File: rtl/seq_match_pkg.sv
// Shared types and width helpers for the key-sequence matcher.
package seq_match_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_HIT,
    ST_MISS,
    ST_RELEASE,
    ST_DONE,
    ST_FAIL,
    ST_END
  } state_t;

  localparam int unsigned KEY_NONE = 0;

  function automatic int idx_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  function automatic int lvl_width(input int num_levels);
    return ($clog2(num_levels) < 1) ? 1 : $clog2(num_levels);
  endfunction

  function automatic int life_width(input int lives);
    return $clog2(lives + 1);
  endfunction

endpackage

// File: rtl/seq_match_engine_index.sv
// Sequence position counter with expected-key selection and last-key detect.
module seq_index_ctr
  import seq_match_pkg::*;
#(
  parameter int KEY_W   = 4,
  parameter int MAX_LEN = 8,
  parameter int IDX_W   = idx_width(MAX_LEN)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     incr,
  input  logic [MAX_LEN*KEY_W-1:0] seq_data,
  input  logic [IDX_W-1:0]         seq_len,
  output logic [IDX_W-1:0]         seq_idx,
  output logic [KEY_W-1:0]         expected_key,
  output logic                     last_key
);

  logic [IDX_W-1:0] len_clamped;

  // Zero length behaves as a one-key sequence; oversize lengths clip to MAX_LEN.
  always_comb begin
    len_clamped = seq_len;
    if (seq_len == '0)
      len_clamped = IDX_W'(1);
    else if (int'(seq_len) > MAX_LEN)
      len_clamped = IDX_W'(MAX_LEN);
  end

  assign last_key = ({1'b0, seq_idx} + (IDX_W+1)'(1)) == {1'b0, len_clamped};

  always_comb begin
    expected_key = KEY_W'(KEY_NONE);
    for (int i = 0; i < MAX_LEN; i++)
      if (seq_idx == IDX_W'(i))
        expected_key = seq_data[i*KEY_W +: KEY_W];
  end

  always_ff @(posedge clk) begin
    if (reset || clear)
      seq_idx <= '0;
    else if (incr && seq_idx != IDX_W'(MAX_LEN))
      seq_idx <= seq_idx + IDX_W'(1);
  end

endmodule

// File: rtl/seq_match_engine.sv
// Key-sequence matcher: tracks progress, level and lives; Moore event pulses.
module seq_match_engine
  import seq_match_pkg::*;
#(
  parameter  int KEY_W      = 4,
  parameter  int MAX_LEN    = 8,
  parameter  int NUM_LEVELS = 4,
  parameter  int LIVES      = 3,
  parameter  int STRICT     = 1,
  localparam int IDX_W      = idx_width(MAX_LEN),
  localparam int LVL_W      = lvl_width(NUM_LEVELS),
  localparam int LIFE_W     = life_width(LIVES)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [KEY_W-1:0]         key_pressed,
  input  logic                     timer_done,
  input  logic [MAX_LEN*KEY_W-1:0] seq_data,
  input  logic [IDX_W-1:0]         seq_len,
  output logic [LVL_W-1:0]         level,
  output logic [IDX_W-1:0]         seq_idx,
  output logic [KEY_W-1:0]         expected_key,
  output logic                     key_match,
  output logic                     seq_reset,
  output logic                     lose_life,
  output logic                     level_up,
  output logic [LIFE_W-1:0]        lives_left,
  output logic                     game_won,
  output logic                     game_over
);

  state_t state, state_nxt;
  logic   start_game, key_any, key_hit, last_key, idx_clear, last_level;

  assign start_game = start && (state == ST_IDLE || state == ST_END);
  assign key_any    = key_pressed != KEY_W'(KEY_NONE);
  assign key_hit    = key_any && (key_pressed == expected_key);
  assign last_level = level >= LVL_W'(NUM_LEVELS - 1);
  assign idx_clear  = start_game || state == ST_MISS || state == ST_FAIL || state == ST_DONE;

  seq_index_ctr #(.KEY_W(KEY_W), .MAX_LEN(MAX_LEN), .IDX_W(IDX_W)) u_index (
    .clk          (clk),
    .reset        (reset),
    .clear        (idx_clear),
    .incr         (state == ST_HIT),
    .seq_data     (seq_data),
    .seq_len      (seq_len),
    .seq_idx      (seq_idx),
    .expected_key (expected_key),
    .last_key     (last_key)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_END: if (start) state_nxt = ST_SCAN;
      ST_SCAN: begin
        if (timer_done)   state_nxt = ST_FAIL;
        else if (key_hit) state_nxt = ST_HIT;
        else if (key_any) state_nxt = ST_MISS;
      end
      ST_HIT:  state_nxt = last_key ? ST_DONE : ST_RELEASE;
      ST_MISS: state_nxt = (STRICT != 0) ? ST_FAIL : ST_RELEASE;
      ST_RELEASE: begin
        if (timer_done)    state_nxt = ST_FAIL;
        else if (!key_any) state_nxt = ST_SCAN;
      end
      ST_DONE: state_nxt = last_level ? ST_END : ST_RELEASE;
      ST_FAIL: state_nxt = (lives_left <= LIFE_W'(1)) ? ST_END : ST_RELEASE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign key_match = state == ST_HIT;
  assign seq_reset = state == ST_MISS || state == ST_FAIL;
  assign lose_life = state == ST_FAIL;
  assign level_up  = state == ST_DONE;

  always_ff @(posedge clk) begin
    if (reset || start_game) begin
      level      <= '0;
      lives_left <= LIFE_W'(LIVES);
      game_won   <= 1'b0;
      game_over  <= 1'b0;
    end else begin
      if (state == ST_DONE) begin
        if (last_level) game_won <= 1'b1;
        else            level    <= level + LVL_W'(1);
      end
      if (state == ST_FAIL) begin
        if (lives_left != '0)          lives_left <= lives_left - LIFE_W'(1);
        if (lives_left <= LIFE_W'(1))  game_over  <= 1'b1;
      end
    end
  end

endmodule
